// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / stall / flush controller with saturating perf counters
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt   ID source registers and their use flags
//   id_branch, branch_taken      ID compares operands / ID redirect resolved taken
//   ex_rd, ex_regwrite, ex_memread   EX destination and write/load flags
//   mem_rd, mem_memread          MEM destination and load flag
//   imem_ready                   instruction word valid for current PC
//   dmem_req, dmem_ready         MEM data access pending / complete
//   *_enable                     stage register load enables
//   ifid_flush, idex_bubble      nop insertion into IF/ID and ID/EX
//   pc_redirect                  PC mux selects branch target
//   busy                         multi-cycle hazard stall in progress
//   stall_cnt, flush_cnt         saturating performance counters
module pipe_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_branch,
    input  logic        branch_taken,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  mem_rd,
    input  logic        mem_memread,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_enable,
    output logic        ifid_enable,
    output logic        idex_enable,
    output logic        exmem_enable,
    output logic        memwb_enable,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pc_redirect,
    output logic        busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HSTALL = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_rem;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic [0:0]  w_state;
    logic [1:0]  w_rem;
    logic        w_ex_hit;
    logic        w_mem_hit;
    logic [1:0]  w_need;
    logic        w_freeze;
    logic        w_run;
    logic        w_haz;
    logic        w_redir;
    logic        w_fwait;
    logic [0:0]  w_state_nxt;
    logic [1:0]  w_rem_nxt;

    // while reset is asserted the outputs reflect the post-reset state
    assign w_state = reset ? RUN : r_state;
    assign w_rem   = reset ? 2'd0 : r_rem;

    assign w_ex_hit  = ex_regwrite & (ex_rd != 5'd0) &
                       ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));
    assign w_mem_hit = mem_memread & (mem_rd != 5'd0) &
                       ((id_use_rs & (mem_rd == id_rs)) | (id_use_rt & (mem_rd == id_rt)));

    // load feeding a branch compare needs two bubbles, other hazards one
    assign w_need = (id_branch & w_ex_hit & ex_memread) ? 2'd2 :
                    ((w_ex_hit & ex_memread) | (id_branch & w_ex_hit) | (id_branch & w_mem_hit)) ? 2'd1 :
                    2'd0;

    assign w_freeze = dmem_req & ~dmem_ready;
    assign w_run    = ~w_freeze & (w_state == RUN) & (w_need == 2'd0);
    assign w_haz    = ~w_freeze & ((w_state == HSTALL) | (w_need != 2'd0));
    // a taken branch beats a fetch wait: fetch restarts at the target
    assign w_redir  = w_run & branch_taken;
    assign w_fwait  = w_run & ~branch_taken & ~imem_ready;

    assign pc_enable    = ~w_freeze & ~w_haz & ~w_fwait;
    assign ifid_enable  = ~w_freeze & ~w_haz;
    assign idex_enable  = ~w_freeze;
    assign exmem_enable = ~w_freeze;
    assign memwb_enable = ~w_freeze;
    assign ifid_flush   = w_redir | w_fwait;
    assign idex_bubble  = w_haz;
    assign pc_redirect  = w_redir;
    assign busy         = (w_state == HSTALL);
    assign stall_cnt    = reset ? 16'd0 : r_stall_cnt;
    assign flush_cnt    = reset ? 16'd0 : r_flush_cnt;

    always_comb begin
        w_state_nxt = w_state;
        w_rem_nxt   = w_rem;
        if (!w_freeze) begin
            if (w_state == HSTALL) begin
                w_state_nxt = (w_rem == 2'd1) ? RUN : HSTALL;
                w_rem_nxt   = w_rem - 2'd1;
            end else if (w_need == 2'd2) begin
                w_state_nxt = HSTALL;
                w_rem_nxt   = 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_rem       <= 2'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (!pc_enable && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (pc_redirect && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic        id_use_rs = 0, id_use_rt = 0, id_branch = 0, branch_taken = 0;
    logic        ex_regwrite = 0, ex_memread = 0, mem_memread = 0;
    logic        imem_ready = 1, dmem_req = 0, dmem_ready = 1;
    logic        pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
    logic        ifid_flush, idex_bubble, pc_redirect, busy;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_ctrl dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .branch_taken(branch_taken), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_memread(mem_memread),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
        .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_redirect(pc_redirect),
        .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, exrd, memrd;
        logic       urs, urt, br, bt, exw, exm, memm, imr, dreq, drdy;
    } stim_t;

    typedef struct {
        logic [8:0]  ctl;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    int    hold = 0;
    int    m_stall = 0;
    int    m_flush = 0;
    stim_t s;

    function automatic int need_of(input stim_t x);
        bit exh, memh;
        exh  = x.exw && x.exrd != 0 && ((x.urs && x.exrd == x.rs) || (x.urt && x.exrd == x.rt));
        memh = x.memm && x.memrd != 0 && ((x.urs && x.memrd == x.rs) || (x.urt && x.memrd == x.rt));
        if (x.br && exh && x.exm) return 2;
        if ((exh && x.exm) || (x.br && exh) || (x.br && memh)) return 1;
        return 0;
    endfunction

    task automatic step(input stim_t x);
        exp_t e;
        int   h, need, sc, fc;
        bit   frz, haz, red, fw, pcen;
        @(posedge clock);
        #1;
        reset = x.rst; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs; id_use_rt = x.urt;
        id_branch = x.br; branch_taken = x.bt; ex_rd = x.exrd; ex_regwrite = x.exw;
        ex_memread = x.exm; mem_rd = x.memrd; mem_memread = x.memm;
        imem_ready = x.imr; dmem_req = x.dreq; dmem_ready = x.drdy;
        h    = x.rst ? 0 : hold;
        sc   = x.rst ? 0 : m_stall;
        fc   = x.rst ? 0 : m_flush;
        need = need_of(x);
        frz  = x.dreq && !x.drdy;
        haz  = !frz && (h > 0 || need > 0);
        red  = !frz && h == 0 && need == 0 && x.bt;
        fw   = !frz && h == 0 && need == 0 && !x.bt && !x.imr;
        pcen = !frz && !haz && !fw;
        e.ctl = {pcen, !frz && !haz, !frz, !frz, !frz, red || fw, haz, red, h > 0};
        e.sc  = 16'(sc);
        e.fc  = 16'(fc);
        q.push_back(e);
        if (x.rst) begin
            hold = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!frz) hold = (h > 0) ? h - 1 : (need == 2 ? 1 : 0);
            if (!pcen && m_stall < 65535) m_stall++;
            if (red && m_flush < 65535) m_flush++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                       ifid_flush, idex_bubble, pc_redirect, busy};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0t act=%b exp=%b", $time, act, e.ctl);
                end
                checks++;
                if (stall_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t act=%h exp=%h", $time, stall_cnt, e.sc);
                end
                checks++;
                if (flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL flush_cnt t=%0t act=%h exp=%h", $time, flush_cnt, e.fc);
                end
            end
        end
    end

    function automatic stim_t idle();
        stim_t x;
        x = '{rst: 0, rs: 0, rt: 0, exrd: 0, memrd: 0, urs: 0, urt: 0, br: 0, bt: 0,
              exw: 0, exm: 0, memm: 0, imr: 1, dreq: 0, drdy: 1};
        return x;
    endfunction

    function automatic stim_t load_use(input bit br);
        stim_t x;
        x = idle();
        x.exm = 1; x.exw = 1; x.exrd = 5; x.rs = 5; x.urs = 1; x.br = br;
        return x;
    endfunction

    function automatic stim_t rnd();
        stim_t x;
        x.rst = ($urandom_range(0, 63) == 0);
        x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
        x.exrd = 5'($urandom_range(0, 3)); x.memrd = 5'($urandom_range(0, 3));
        x.urs = 1'($urandom); x.urt = 1'($urandom); x.br = 1'($urandom);
        x.bt = 1'($urandom); x.exw = 1'($urandom); x.exm = 1'($urandom);
        x.memm = 1'($urandom); x.imr = ($urandom_range(0, 3) != 0);
        x.dreq = ($urandom_range(0, 3) == 0); x.drdy = 1'($urandom);
        return x;
    endfunction

    initial begin
        s = idle(); s.rst = 1;
        step(s); step(s);
        step(idle());
        step(load_use(0)); step(idle());
        step(load_use(1)); step(rnd()); step(idle());
        step(load_use(1));
        s = load_use(1); s.dreq = 1; s.drdy = 0;
        repeat (3) step(s);
        step(rnd()); step(idle());
        s = idle(); s.bt = 1; s.imr = 0;
        step(s); step(idle());
        s = load_use(1); s.exrd = 0; s.rs = 0;
        step(s);
        s = idle(); s.imr = 0;
        repeat (65540) step(s);
        step(idle());
        step(load_use(1));
        s = load_use(1); s.rst = 1;
        step(s); step(idle()); step(idle());
        repeat (3000) begin
            s = rnd();
            step(s);
        end
        @(posedge clock);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list (name  direction  width  meaning) SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- id_rs, id_rt  in  5 each  source register fields of the ID instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- id_branch  in  1  ID instruction compares operands in ID (beq/bne/jr)
- branch_taken  in  1  ID redirect resolved taken
- ex_rd  in  5  EX destination register
- ex_regwrite, ex_memread  in  1 each  EX writes a register / EX is a load
- mem_rd  in  5  MEM destination register
- mem_memread  in  1  MEM is a load
- imem_ready  in  1  instruction word valid for current PC
- dmem_req, dmem_ready  in  1 each  MEM data access pending / complete
- pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable  out  1 each  stage register load enables
- ifid_flush  out  1  IF/ID loads all-zero (nop) at next edge
- idex_bubble  out  1  ID/EX loads nop at next edge
- pc_redirect  out  1  PC mux selects branch target
- busy  out  1  FSM in HSTALL
- stall_cnt, flush_cnt  out  16 each  saturating performance counters

Function
REQ-003 Definitions: ex_hit = ex_regwrite & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)); mem_hit = mem_memread & mem_rd!=0 & (same rs/rt match against mem_rd).
REQ-004 Hazard length need SHALL be: 2 if id_branch & ex_hit & ex_memread; else 1 if (ex_hit & ex_memread) | (id_branch & ex_hit) | (id_branch & mem_hit); else 0.
REQ-005 freeze = dmem_req & ~dmem_ready SHALL force all five enables to 0 and flush/bubble/redirect to 0, in any state, holding FSM state and remaining count unchanged.
REQ-006 Output modes: HAZ = pc_enable 0, ifid_enable 0, idex_bubble 1, other enables 1; REDIRECT = all enables 1, pc_redirect 1, ifid_flush 1; FETCHWAIT = pc_enable 0, ifid_enable 1, ifid_flush 1, other enables 1; NORMAL = all enables 1, flush/bubble/redirect 0.
REQ-007 Outputs SHALL be combinational from current state, remaining count and inputs (Mealy).
REQ-008 FSM states SHALL be RUN and HSTALL with a 2-bit remaining-count register rem.
REQ-009 In RUN, not frozen, priority SHALL be: need>0 -> HAZ; else branch_taken -> REDIRECT; else ~imem_ready -> FETCHWAIT; else NORMAL.
REQ-010 In RUN with HAZ: if need==2, next state HSTALL with rem=1; if need==1, stay RUN.
REQ-011 In HSTALL, not frozen: output HAZ irrespective of inputs; hazard inputs and branch_taken SHALL be ignored; rem decrements; when rem==1 at the edge, next state RUN with rem=0.
REQ-012 branch_taken coincident with need>0 SHALL NOT redirect; branch re-evaluated once the stall ends.
REQ-013 branch_taken coincident with ~imem_ready SHALL produce REDIRECT (fetch restarts at target).
REQ-014 stall_cnt SHALL increment on each edge where pc_enable==0, saturating at 0xFFFF.
REQ-015 flush_cnt SHALL increment on each edge where pc_redirect==1, saturating at 0xFFFF.
REQ-016 busy SHALL be 1 exactly when state is HSTALL.

Reset
REQ-017 reset sampled high at a rising edge SHALL set state RUN, rem 0, stall_cnt 0, flush_cnt 0; it overrides freeze and any in-progress HSTALL.
REQ-018 While reset is high, outputs SHALL be evaluated from the reset state (RUN, no stall history).

Verification
REQ-019 Load-use: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs=5, id_use_rs=1, id_branch=0 -> one HAZ cycle (pc_enable=0, idex_bubble=1), state stays RUN, stall_cnt +1.
REQ-020 Load-to-branch: same with id_branch=1 -> HAZ for 2 cycles, busy=1 in cycle 2 even though inputs change; then NORMAL; stall_cnt +2.
REQ-021 Freeze inside HSTALL: dmem_req=1, dmem_ready=0 for 3 cycles during cycle 2 of a load-to-branch stall -> all enables 0 for 3 cycles, rem held, one HAZ cycle after release; stall_cnt +4 total beyond first HAZ.
REQ-022 Branch vs fetch wait: branch_taken=1, imem_ready=0, no hazard -> pc_redirect=1, ifid_flush=1, pc_enable=1; flush_cnt +1, stall_cnt unchanged.
REQ-023 Register 0 and saturation: ex_rd=0 matching id_rs=0 -> NORMAL; stall_cnt preloaded to 0xFFFF by 65535 FETCHWAIT cycles stays 0xFFFF; reset mid-HSTALL -> RUN, counters 0 next cycle.
